seg7_scan_mux: RTL and testbench



---
 rtl/seg7_scan_mux.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit hex driver for a common-anode display: double-buffered digit word,
// per-digit dp/blank, PWM brightness, break-before-make and a frame-start tick.
module seg7_scan_mux #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ON_W   = BRIGHT_W + 1 + $clog2(SCAN_DIV + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic                pend_valid_q, pend_valid_d;
    logic                bnd_q, bnd_d;
    logic                tick_q, tick_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                slot_wrap;
    logic                boundary;
    logic                lit;
    logic [ON_W-1:0]     on_time;
    logic [3:0]          nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
            4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
            4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
            4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
        endcase
        return s;
    endfunction

    // Scan counters, buffer swap and registered display outputs
    always_comb begin
        slot_d       = slot_q;
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        an_d         = '1;

        slot_wrap = (slot_q == SLOT_LAST);
        boundary  = slot_wrap && (idx_q == IDX_LAST);
        bnd_d     = boundary;
        tick_d    = bnd_q;

        if (slot_wrap) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end

        // A load coinciding with the boundary bypasses pending and goes live this frame
        if (boundary) begin
            if (load) begin
                act_data_d  = wr_data;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
            end else if (pend_valid_q) begin
                act_data_d  = pend_data_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_data_d  = wr_data;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end

        on_time = ((ON_W'(brightness) + ON_W'(1)) * ON_W'(SCAN_DIV)) >> BRIGHT_W;
        nibble  = act_data_q[{idx_q, 2'b00} +: 4];
        lit     = (ON_W'(slot_q) < on_time) && !slot_wrap && !act_blank_q[idx_q];

        if (lit) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = hex_to_seg(nibble);
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q       <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            pend_valid_q <= 1'b0;
            bnd_q        <= 1'b0;
            tick_q       <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            bnd_q        <= bnd_d;
            tick_q       <= tick_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DIGITS=4, SCAN_DIV=8, BRIGHT_W=2.
module tb_seg7_scan_mux;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned BRIGHT_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] wr_data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // clock edges since the reset edge

    seg7_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .wr_data(wr_data), .dp_in(dp_in),
        .blank_in(blank_in), .brightness(brightness), .seg(seg), .dp(dp), .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;  4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;  4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;  4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;  4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Expected {frame_tick, an, seg, dp} after edge kk, for a given displayed word
    function automatic logic [12:0] exp_out(input logic [15:0] data, input logic [3:0] dpv,
                                            input logic [3:0] blk, input int br, input int kk);
        int s, slot, d, on_t;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic dp_e, tk;
        s     = kk - 1;
        slot  = s % 8;
        d     = (s / 8) % 4;
        on_t  = ((br + 1) * 8) >> 2;
        tk    = (kk >= 33) && (kk % 32 == 1);
        an_e  = 4'hF;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        if (slot < on_t && slot != 7 && !blk[d]) begin
            an_e[d] = 1'b0;
            seg_e   = dec(data[4*d +: 4]);
            dp_e    = ~dpv[d];
        end
        return {tk, an_e, seg_e, dp_e};
    endfunction

    function automatic int next_start();
        return ((k + 31) / 32) * 32 + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_to(input int t);
        while (k < t) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        load = 1'b1; wr_data = d; dp_in = p; blank_in = b;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        k = 0;
        checks++;
        if ({frame_tick, an, seg, dp} !== {1'b0, 4'hF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", {frame_tick, an, seg, dp}, {1'b0, 4'hF, 7'h7F, 1'b1});
        end
        for (int i = 0; i < 100; i++) begin
            step();
            e = exp_out(16'h0, 4'h0, 4'hF, 3, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL idle k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
    endtask

    task automatic test_digits();
        logic [12:0] e;
        int fr;
        do_load(16'h3210, 4'b0100, 4'b0000);
        fr = next_start();
        wait_to(fr - 1);
        for (int i = 0; i < 32; i++) begin
            step();
            e = exp_out(16'h3210, 4'b0100, 4'b0000, 3, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL digits k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
    endtask

    task automatic test_all_codes();
        logic [15:0] words [4];
        logic [12:0] e;
        int fr;
        words[0] = 16'hFEDC; words[1] = 16'hBA98; words[2] = 16'h7654; words[3] = 16'h3210;
        for (int w = 0; w < 4; w++) begin
            do_load(words[w], 4'b0000, 4'b0000);
            fr = next_start();
            wait_to(fr - 1);
            for (int i = 0; i < 32; i++) begin
                step();
                e = exp_out(words[w], 4'b0000, 4'b0000, 3, k);
                checks++;
                if ({frame_tick, an, seg, dp} !== e) begin
                    failures++;
                    $display("FAIL codes_%h k=%0d got=%h exp=%h", words[w], k, {frame_tick, an, seg, dp}, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        int fr;
        wait_to(k + (42 - k % 32) % 32);
        do_load(16'h1111, 4'b0000, 4'b0000);
        fr = next_start();
        while (k % 32 != 20) begin
            step();
            e = exp_out(16'h3210, 4'b0000, 4'b0000, 3, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL hold_old k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
        do_load(16'h2222, 4'b0000, 4'b0000);
        while (k < fr + 31) begin
            step();
            e = exp_out((k >= fr) ? 16'h2222 : 16'h3210, 4'b0000, 4'b0000, 3, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL overwrite k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [12:0] e;
        int fr;
        wait_to(k + (63 - k % 32) % 32);
        do_load(16'h9876, 4'b0001, 4'b0000);
        fr = next_start();
        checks++;
        if (fr != k + 1) begin
            failures++;
            $display("FAIL boundary_align k=%0d got=%0d exp=%0d", k, fr, k + 1);
        end
        wait_to(fr - 1);
        for (int i = 0; i < 64; i++) begin
            step();
            e = exp_out(16'h9876, 4'b0001, 4'b0000, 3, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL boundary_load k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
    endtask

    task automatic test_bright_blank();
        logic [12:0] e;
        int fr;
        brightness = 2'd0;
        do_load(16'h3210, 4'b0000, 4'b1010);
        fr = next_start();
        wait_to(fr - 1);
        for (int i = 0; i < 32; i++) begin
            step();
            e = exp_out(16'h3210, 4'b0000, 4'b1010, 0, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL bright_blank k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        brightness = 2'd3;
        wait_to(k + (35 - k % 32) % 32);
        do_load(16'h8888, 4'b1111, 4'b0000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        k = 0;
        checks++;
        if ({frame_tick, an, seg, dp} !== {1'b0, 4'hF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid k=0 got=%h exp=%h", {frame_tick, an, seg, dp}, {1'b0, 4'hF, 7'h7F, 1'b1});
        end
        for (int i = 0; i < 70; i++) begin
            step();
            e = exp_out(16'h0, 4'h0, 4'hF, 3, k);
            checks++;
            if ({frame_tick, an, seg, dp} !== e) begin
                failures++;
                $display("FAIL after_reset k=%0d got=%h exp=%h", k, {frame_tick, an, seg, dp}, e);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        wr_data    = 16'h0;
        dp_in      = 4'h0;
        blank_in   = 4'h0;
        brightness = 2'd3;
        test_reset();
        test_digits();
        test_all_codes();
        test_back_to_back();
        test_boundary_load();
        test_bright_blank();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
